// File: rtl/router_ctrl_fsm.sv
// Control FSM of the 1x3 packet router: decodes the header address and sequences header/payload/parity loads.
// Define ROUTER_FSM_STATE_DBG_EN to add the state_dbg output carrying the raw state register.
module router_ctrl_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
`ifdef ROUTER_FSM_STATE_DBG_EN
  ,
  output logic [2:0] state_dbg
`endif
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [1:0] addr;
  logic       fifo_empty_addr;
  logic       soft_reset_sel;

  always_ff @(posedge clock) begin
    if (resetn) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS) addr <= data_in;
    end
  end

  // Only the port currently latched in addr can soft-reset the FSM; address 3 selects no port.
  always_comb begin
    fifo_empty_addr = 1'b0;
    soft_reset_sel  = 1'b0;
    case (addr)
      2'd0: begin fifo_empty_addr = fifo_empty_0; soft_reset_sel = soft_reset_0; end
      2'd1: begin fifo_empty_addr = fifo_empty_1; soft_reset_sel = soft_reset_1; end
      2'd2: begin fifo_empty_addr = fifo_empty_2; soft_reset_sel = soft_reset_2; end
      default: begin fifo_empty_addr = 1'b0; soft_reset_sel = 1'b0; end
    endcase
  end

  always_comb begin
    next_state = state;
    if (soft_reset_sel) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            case (data_in)
              2'd0: next_state = fifo_empty_0 ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
              2'd1: next_state = fifo_empty_1 ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
              2'd2: next_state = fifo_empty_2 ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
              default: next_state = DECODE_ADDRESS;
            endcase
          end
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
        end
        FIFO_FULL_STATE: if (!fifo_full) next_state = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        next_state = DECODE_ADDRESS;
          else if (low_pkt_valid) next_state = LOAD_PARITY;
          else                    next_state = LOAD_DATA;
        end
        LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:    if (fifo_empty_addr) next_state = LOAD_FIRST_DATA;
        default:            next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // Handshake: while busy=1 the input side must hold pkt_valid/data_in; when busy=0
  // (DECODE_ADDRESS, LOAD_DATA) the current input byte is consumed at the next rising edge.
  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

`ifdef ROUTER_FSM_STATE_DBG_EN
  assign state_dbg = state;
`endif

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Bench for router_ctrl_fsm: directed test-plan steps followed by randomized cycles scored against a reference model.
module tb_router_ctrl_fsm;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
`ifdef ROUTER_FSM_STATE_DBG_EN
  logic [2:0] state_dbg;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Reference model: state numbers as named in the packet-router description.
  localparam int DEC = 0, LFD = 1, LD = 2, LP = 3, FULL = 4, LAF = 5, WTE = 6, CPE = 7;
  int         m_state = DEC;
  logic [1:0] m_addr = 2'd0;

  router_ctrl_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
`ifdef ROUTER_FSM_STATE_DBG_EN
    , .state_dbg(state_dbg)
`endif
  );

  // Clock
  always #5 clock = ~clock;

  // Output vector {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy} expected in each state.
  function automatic logic [7:0] flags_of(input int s);
    case (s)
      DEC:     return 8'b1000_0000;
      LFD:     return 8'b0100_0001;
      LD:      return 8'b0010_0100;
      LP:      return 8'b0000_0101;
      FULL:    return 8'b0000_1001;
      LAF:     return 8'b0001_0101;
      WTE:     return 8'b0000_0001;
      default: return 8'b0000_0011;
    endcase
  endfunction

  task automatic model_step();
    logic [2:0] sr, fe;
    int nxt;
    sr = {soft_reset_2, soft_reset_1, soft_reset_0};
    fe = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    if (resetn) begin
      m_state = DEC;
      m_addr  = 2'd0;
      return;
    end
    nxt = m_state;
    if (m_addr != 2'd3 && sr[m_addr]) nxt = DEC;
    else if (m_state == DEC) begin
      if (pkt_valid && data_in != 2'd3) nxt = fe[data_in] ? LFD : WTE;
    end
    else if (m_state == LFD) nxt = LD;
    else if (m_state == LD) nxt = fifo_full ? FULL : (pkt_valid ? LD : LP);
    else if (m_state == FULL) nxt = fifo_full ? FULL : LAF;
    else if (m_state == LAF) nxt = parity_done ? DEC : (low_pkt_valid ? LP : LD);
    else if (m_state == LP) nxt = CPE;
    else if (m_state == CPE) nxt = fifo_full ? FULL : DEC;
    else if (m_state == WTE) nxt = fe[m_addr] ? LFD : WTE;
    if (m_state == DEC) m_addr = data_in;
    m_state = nxt;
  endtask

  task automatic check(input string tag);
    logic [7:0] obs, e;
    obs = {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy};
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $display("FAIL %s: observed %b expected %b", tag, obs, e);
      $error("output check %s", tag);
    end
  endtask

  // Driver: inputs are already applied; clock one edge and score the outputs.
  // exp_state < 0 takes the expectation from the reference model.
  task automatic step(input string tag, input int exp_state);
    model_step();
    exp_q.push_back(flags_of(exp_state < 0 ? m_state : exp_state));
    @(posedge clock);
    #1;
    check(tag);
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; parity_done = 0; low_pkt_valid = 0; fifo_full = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
  endtask

  task automatic header(input logic [1:0] a);
    pkt_valid = 1; data_in = a;
  endtask

  initial begin
    // Reset
    idle_inputs();
    resetn = 1;
    step("reset_0", DEC);
    step("reset_1", DEC);
    resetn = 0;
    step("idle", DEC);

    // Port 0 normal packet
    header(2'd0);  step("p0_lfd", LFD);
    step("p0_ld", LD);
    pkt_valid = 0; step("p0_lp", LP);
    step("p0_cpe", CPE);
    step("p0_dec", DEC);

    // Port 1 full stall, low_pkt_valid path
    header(2'd1);  step("p1_lfd", LFD);
    step("p1_ld", LD);
    fifo_full = 1; step("p1_full", FULL);
    fifo_full = 0; step("p1_laf", LAF);
    low_pkt_valid = 1; step("p1_lp", LP);
    low_pkt_valid = 0; pkt_valid = 0; step("p1_cpe", CPE);
    step("p1_dec", DEC);

    // Port 2 full stall then resume
    header(2'd2);  step("p2_lfd", LFD);
    step("p2_ld", LD);
    fifo_full = 1; step("p2_full", FULL);
    step("p2_full_hold", FULL);
    fifo_full = 0; step("p2_laf", LAF);
    step("p2_resume_ld", LD);
    pkt_valid = 0; step("p2_lp", LP);
    step("p2_cpe", CPE);
    step("p2_dec", DEC);

    // Full after parity, parity_done exit
    header(2'd0);  step("fap_lfd", LFD);
    step("fap_ld", LD);
    pkt_valid = 0; step("fap_lp", LP);
    step("fap_cpe", CPE);
    fifo_full = 1; step("fap_full", FULL);
    fifo_full = 0; step("fap_laf", LAF);
    parity_done = 1; step("fap_dec", DEC);
    parity_done = 0;

    // Invalid address is ignored
    header(2'd3);  step("addr3_stay", DEC);
    step("addr3_stay2", DEC);

    // Wait till empty
    header(2'd0); fifo_empty_0 = 0; step("wte_enter", WTE);
    step("wte_hold", WTE);
    fifo_empty_0 = 1; step("wte_lfd", LFD);
    pkt_valid = 0; step("wte_ld", LD);
    step("wte_lp", LP);
    step("wte_cpe", CPE);
    step("wte_dec", DEC);

    // Soft reset: non-selected port ignored, selected port returns to decode
    header(2'd0); fifo_empty_0 = 0; step("sr_wte", WTE);
    soft_reset_1 = 1; step("sr_other_ignored", WTE);
    soft_reset_1 = 0; soft_reset_0 = 1; step("sr_sel_dec", DEC);
    idle_inputs();
    step("sr_idle", DEC);
    header(2'd2); step("sr2_lfd", LFD);
    step("sr2_ld", LD);
    soft_reset_0 = 1; step("sr2_other_ignored", LD);
    soft_reset_0 = 0; soft_reset_2 = 1; step("sr2_sel_dec", DEC);
    idle_inputs();
    step("sr2_idle", DEC);

    // Randomized cycles scored against the reference model
    for (int i = 0; i < 600; i++) begin
      resetn        = ($urandom_range(0, 63) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 2) == 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 2) != 0);
      soft_reset_0  = ($urandom_range(0, 15) == 0);
      soft_reset_1  = ($urandom_range(0, 15) == 0);
      soft_reset_2  = ($urandom_range(0, 15) == 0);
      step("random", -1);
    end

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
